// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer
// Initiator-side sequencer for the ALU_TOP datapath. Operation requests are
// queued, issued one at a time onto A/B/ALU_FUN, and after a fixed ALU
// latency the ALU result is captured and handed upstream together with the
// unit class taken from ALU_FUN[3:2]. All ALU traffic is serialised here.
//
// Handshake rule (both ports): a transfer occurs on a rising CLK edge where
// VALID and READY are both high. CMD_READY depends only on queue occupancy
// (never on CMD_VALID or a same-cycle pop). RES_VALID rises only on a capture
// edge, then stays high with RES_DATA/RES_CLASS held until the transfer edge.
module alu_cmd_issuer #(
  parameter int DATA_WIDTH = 16,
  parameter int FIFO_DEPTH = 4,  // power of two, at least 2
  parameter int ALU_LAT    = 1   // ALU register stages, 0 = combinational ALU
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  CMD_VALID,
  output logic                  CMD_READY,
  input  logic [3:0]            CMD_FUN,
  input  logic [DATA_WIDTH-1:0] CMD_A,
  input  logic [DATA_WIDTH-1:0] CMD_B,
  output logic [DATA_WIDTH-1:0] A,
  output logic [DATA_WIDTH-1:0] B,
  output logic [3:0]            ALU_FUN,
  input  logic [DATA_WIDTH-1:0] ALU_OUT,
  output logic                  RES_VALID,
  input  logic                  RES_READY,
  output logic [DATA_WIDTH-1:0] RES_DATA,
  output logic [1:0]            RES_CLASS,
  output logic                  BUSY,
  output logic [1:0]            DBG_STATE
);

  // Pointer, occupancy and latency-counter widths.
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int LW = (ALU_LAT > 0) ? $clog2(ALU_LAT + 1) : 1;
  // Queue entry layout: {fun, a, b}.
  localparam int EW = 4 + 2 * DATA_WIDTH;

  // IDLE: nothing issued; WAIT: ALU evaluating; DONE: result held for upstream.
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // Command queue storage and bookkeeping.
  logic [EW-1:0]         mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_q;
  logic                  full;
  logic                  empty;
  logic                  push;
  logic                  pop;
  logic [EW-1:0]         head;
  logic [3:0]            head_fun;
  logic [DATA_WIDTH-1:0] head_a;
  logic [DATA_WIDTH-1:0] head_b;

  // Sequencer state.
  state_t                state_q;
  state_t                state_d;
  logic [LW-1:0]         lat_q;
  logic [LW-1:0]         lat_d;
  logic                  capture;
  logic                  res_take;

  assign full      = (count_q == CW'(FIFO_DEPTH));
  assign empty     = (count_q == '0);
  assign CMD_READY = ~full;
  assign push      = CMD_VALID & CMD_READY;

  assign head      = mem[rd_ptr];
  assign head_fun  = head[EW-1 -: 4];
  assign head_a    = head[2*DATA_WIDTH-1 -: DATA_WIDTH];
  assign head_b    = head[DATA_WIDTH-1:0];

  assign BUSY      = (state_q != S_IDLE) || !empty;
  assign DBG_STATE = state_q;

  // Queue storage: written on push only; reset flushes via pointers/count.
  always_ff @(posedge CLK) begin
    if (push) begin
      mem[wr_ptr] <= {CMD_FUN, CMD_A, CMD_B};
    end
  end

  // Queue pointers and occupancy; pointers wrap naturally (power-of-two depth).
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Sequencer state and ALU latency counter.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= S_IDLE;
      lat_q   <= '0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
    end
  end

  // Next-state logic: decides pops, result capture and result hand-off.
  // Issuing the next command in DONE shares the hand-off edge, so a steady
  // stream costs ALU_LAT+2 cycles per command.
  always_comb begin
    state_d  = state_q;
    lat_d    = lat_q;
    pop      = 1'b0;
    capture  = 1'b0;
    res_take = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          lat_d   = LW'(ALU_LAT);
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          capture = 1'b1;
          state_d = S_DONE;
        end else begin
          lat_d = lat_q - LW'(1);
        end
      end
      S_DONE: begin
        if (RES_VALID && RES_READY) begin
          res_take = 1'b1;
          if (!empty) begin
            pop     = 1'b1;
            lat_d   = LW'(ALU_LAT);
            state_d = S_WAIT;
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // ALU operand registers: change only on a pop edge so the ALU sees stable
  // inputs for the whole evaluation window.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      A       <= '0;
      B       <= '0;
      ALU_FUN <= '0;
    end else if (pop) begin
      A       <= head_a;
      B       <= head_b;
      ALU_FUN <= head_fun;
    end
  end

  // Result registers: capture ALU_OUT and the unit class; RES_VALID drops
  // only on the hand-off edge. Capture and hand-off never share an edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      RES_DATA  <= '0;
      RES_CLASS <= '0;
      RES_VALID <= 1'b0;
    end else if (capture) begin
      RES_DATA  <= ALU_OUT;
      RES_CLASS <= ALU_FUN[3:2];
      RES_VALID <= 1'b1;
    end else if (res_take) begin
      RES_VALID <= 1'b0;
    end
  end

  // The sequencer never pops an empty queue, and the handshake never pushes
  // into a full one.
  a_no_underflow: assert property (@(posedge CLK) disable iff (RST) pop |-> !empty);
  a_no_overflow:  assert property (@(posedge CLK) disable iff (RST) push |-> !full);

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer
// Directed bench for alu_cmd_issuer with a registered (1-stage) ALU model.
// A scoreboard predicts every result from accepted commands (in order, class
// = fun[3:2]) and checks each cycle RES_VALID is high; directed sections pin
// timing, capacity, class encoding, reset flush and push/pop concurrency.
module tb_alu_cmd_issuer;

  localparam int DW    = 16;
  localparam int DEPTH = 4;
  localparam int LAT   = 1;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_fun;
  logic [DW-1:0] cmd_a;
  logic [DW-1:0] cmd_b;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic [3:0]    alu_fun;
  logic [DW-1:0] alu_out;
  logic          res_valid;
  logic          res_ready;
  logic [DW-1:0] res_data;
  logic [1:0]    res_class;
  logic          busy;
  logic [1:0]    dbg_state;

  // Scoreboard: {class, data} per accepted command, oldest first.
  logic [DW+1:0] exp_q[$];
  logic [DW+1:0] sb_head;
  int            checks = 0;
  int            failures = 0;
  int            accepts = 0;
  int            results_seen = 0;

  // Directed-section scratch.
  int            idx;
  int            accepted;
  bit            took;
  bit            prev_valid;
  bit            seen;
  int            n_rise;
  int            n_got;
  int            rdy_at;
  int            rises [8];
  logic [DW-1:0] got [8];
  int            n_bad_valid;
  int            n_bad_busy;

  // Backpressure commands and their hand-computed results.
  logic [3:0]    bp_fun [6] = '{4'd0, 4'd1, 4'd5, 4'd9, 4'd12, 4'd2};
  logic [DW-1:0] bp_a   [6] = '{16'd10, 16'd50, 16'h00F0, 16'd9, 16'h0010, 16'd6};
  logic [DW-1:0] bp_b   [6] = '{16'd20, 16'd8, 16'h0F00, 16'd3, 16'h0000, 16'd7};
  logic [DW-1:0] bp_res [5] = '{16'd30, 16'd42, 16'h0FF0, 16'd1, 16'h0008};

  // Class-encoding commands.
  logic [3:0]    ce_fun [4] = '{4'b0100, 4'b1000, 4'b1101, 4'b0011};
  logic [DW-1:0] ce_a   [4] = '{16'h00F0, 16'd7, 16'd3, 16'h00FF};
  logic [DW-1:0] ce_b   [4] = '{16'h0FF0, 16'd7, 16'd0, 16'h0F0F};
  logic [DW-1:0] ce_res [4] = '{16'h00F0, 16'd1, 16'd6, 16'h0FF0};
  logic [1:0]    ce_cls [4] = '{2'b01, 2'b10, 2'b11, 2'b00};

  alu_cmd_issuer #(
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(DEPTH),
    .ALU_LAT   (LAT)
  ) dut (
    .CLK      (clk),
    .RST      (rst),
    .CMD_VALID(cmd_valid),
    .CMD_READY(cmd_ready),
    .CMD_FUN  (cmd_fun),
    .CMD_A    (cmd_a),
    .CMD_B    (cmd_b),
    .A        (a),
    .B        (b),
    .ALU_FUN  (alu_fun),
    .ALU_OUT  (alu_out),
    .RES_VALID(res_valid),
    .RES_READY(res_ready),
    .RES_DATA (res_data),
    .RES_CLASS(res_class),
    .BUSY     (busy),
    .DBG_STATE(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- ALU model ----------------
  function automatic logic [DW-1:0] alu_f(input logic [3:0] f, input logic [DW-1:0] x,
                                          input logic [DW-1:0] y);
    logic [DW-1:0] r;
    case (f)
      4'd0:    r = x + y;
      4'd1:    r = x - y;
      4'd2:    r = x * y;
      4'd3:    r = x ^ y;
      4'd4:    r = x & y;
      4'd5:    r = x | y;
      4'd6:    r = ~(x & y);
      4'd7:    r = ~(x | y);
      4'd8:    r = (x == y) ? DW'(1) : DW'(0);
      4'd9:    r = (x > y) ? DW'(1) : DW'(0);
      4'd10:   r = (x < y) ? DW'(1) : DW'(0);
      4'd11:   r = '0;
      4'd12:   r = x >> 1;
      4'd13:   r = x << 1;
      4'd14:   r = {x[DW-1], x[DW-1:1]};
      default: r = x << y[3:0];
    endcase
    return r;
  endfunction

  always @(posedge clk) alu_out <= alu_f(alu_fun, a, b);

  // ---------------- checking helper ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  // ---------------- scoreboard ----------------
  // Sampled on the falling edge: what is seen here is what the next rising
  // edge will act on.
  always @(negedge clk) begin
    if (!rst) begin
      if (res_valid) begin
        chk("sb_result_pending", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          sb_head = exp_q[0];
          chk("sb_res_data", 32'(res_data), 32'(sb_head[DW-1:0]));
          chk("sb_res_class", 32'(res_class), 32'(sb_head[DW+1:DW]));
          if (res_ready) begin
            void'(exp_q.pop_front());
            results_seen++;
          end
        end
      end
      if (cmd_valid && cmd_ready) begin
        exp_q.push_back({cmd_fun[3:2], alu_f(cmd_fun, cmd_a, cmd_b)});
        accepts++;
      end
    end
  end

  // Reset discards every in-flight and queued command.
  always @(posedge rst) exp_q.delete();

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [3:0] f, input logic [DW-1:0] x, input logic [DW-1:0] y);
    bit ok;
    ok        = 1'b0;
    cmd_fun   = f;
    cmd_a     = x;
    cmd_b     = y;
    cmd_valid = 1'b1;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 1'b0;
    chk("push_accepted", 32'(ok), 32'd1);
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_A"}, 32'(a), 32'd0);
    chk({tag, "_B"}, 32'(b), 32'd0);
    chk({tag, "_ALU_FUN"}, 32'(alu_fun), 32'd0);
    chk({tag, "_RES_DATA"}, 32'(res_data), 32'd0);
    chk({tag, "_RES_CLASS"}, 32'(res_class), 32'd0);
    chk({tag, "_RES_VALID"}, 32'(res_valid), 32'd0);
    chk({tag, "_BUSY"}, 32'(busy), 32'd0);
    chk({tag, "_CMD_READY"}, 32'(cmd_ready), 32'd1);
    chk({tag, "_STATE_IDLE"}, 32'(dbg_state), 32'd0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog: run did not complete within time limit");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

  // ---------------- directed stimulus ----------------
  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_fun   = '0;
    cmd_a     = '0;
    cmd_b     = '0;
    res_ready = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    check_reset_values("reset");
    @(posedge clk);
    #1 rst = 1'b0;

    // ---- single op: FUN=0, A=5, B=3, accepted at edge t ----
    res_ready = 1'b1;
    cmd_fun   = 4'b0000;
    cmd_a     = 16'd5;
    cmd_b     = 16'd3;
    cmd_valid = 1'b1;
    @(posedge clk);            // edge t
    #1 cmd_valid = 1'b0;
    @(negedge clk);            // after t
    chk("single_busy_after_accept", 32'(busy), 32'd1);
    chk("single_A_not_yet_issued", 32'(a), 32'd0);
    @(negedge clk);            // after t+1
    chk("single_ALU_FUN", 32'(alu_fun), 32'd0);
    chk("single_A", 32'(a), 32'd5);
    chk("single_B", 32'(b), 32'd3);
    chk("single_no_early_valid_t1", 32'(res_valid), 32'd0);
    @(negedge clk);            // after t+2
    chk("single_no_early_valid_t2", 32'(res_valid), 32'd0);
    @(negedge clk);            // after t+3
    chk("single_RES_VALID", 32'(res_valid), 32'd1);
    chk("single_RES_DATA", 32'(res_data), 32'd8);
    chk("single_RES_CLASS", 32'(res_class), 32'd0);
    @(negedge clk);            // after t+4, handshake done
    chk("single_valid_cleared", 32'(res_valid), 32'd0);
    chk("single_busy_low", 32'(busy), 32'd0);

    // ---- backpressure: 6 commands offered, result port stalled ----
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    idx       = 0;
    accepted  = 0;
    cmd_fun   = bp_fun[0];
    cmd_a     = bp_a[0];
    cmd_b     = bp_b[0];
    cmd_valid = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      took = cmd_ready;
      @(posedge clk);
      #1;
      if (took && cmd_valid) begin
        accepted++;
        idx++;
        if (idx < 6) begin
          cmd_fun = bp_fun[idx];
          cmd_a   = bp_a[idx];
          cmd_b   = bp_b[idx];
        end else begin
          cmd_valid = 1'b0;
        end
      end
    end
    @(negedge clk);
    chk("bp_accepted_count", 32'(accepted), 32'd5);
    chk("bp_cmd_ready_low", 32'(cmd_ready), 32'd0);
    chk("bp_ALU_FUN_frozen", 32'(alu_fun), 32'(bp_fun[0]));
    chk("bp_A_frozen", 32'(a), 32'd10);
    chk("bp_RES_VALID", 32'(res_valid), 32'd1);
    chk("bp_RES_DATA_first", 32'(res_data), 32'd30);
    @(posedge clk);
    #1 cmd_valid = 1'b0;       // withdraw the rejected 6th command

    // ---- drain ----
    res_ready  = 1'b1;         // set just after edge P0
    prev_valid = 1'b1;
    n_rise     = 0;
    n_got      = 0;
    rdy_at     = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);          // sample k is after edge Pk
      if (res_valid && !prev_valid && n_rise < 8) begin
        rises[n_rise] = k;
        n_rise++;
      end
      if (res_valid && res_ready && n_got < 8) begin
        got[n_got] = res_data;
        n_got++;
      end
      if (cmd_ready && rdy_at < 0) rdy_at = k;
      prev_valid = res_valid;
    end
    chk("drain_result_count", 32'(n_got), 32'd5);
    for (int i = 0; i < 5; i++) begin
      if (i < n_got) chk("drain_result_order", 32'(got[i]), 32'(bp_res[i]));
    end
    chk("drain_rise_count", 32'(n_rise), 32'd4);
    if (n_rise > 0) chk("drain_first_rise", 32'(rises[0]), 32'd3);
    for (int i = 1; i < 4; i++) begin
      if (i < n_rise) chk("drain_rise_spacing", 32'(rises[i] - rises[i-1]), 32'd3);
    end
    chk("drain_cmd_ready_reassert", 32'(rdy_at), 32'd1);
    chk("drain_busy_low", 32'(busy), 32'd0);

    // ---- class encoding ----
    @(posedge clk);
    #1;
    res_ready  = 1'b1;
    prev_valid = 1'b0;
    n_rise     = 0;
    fork
      begin
        for (int i = 0; i < 4; i++) push_cmd(ce_fun[i], ce_a[i], ce_b[i]);
      end
      begin
        for (int k = 0; k < 40 && n_rise < 4; k++) begin
          @(negedge clk);
          if (res_valid && !prev_valid) begin
            chk("class_RES_CLASS", 32'(res_class), 32'(ce_cls[n_rise]));
            chk("class_RES_DATA", 32'(res_data), 32'(ce_res[n_rise]));
            chk("class_ALU_FUN_issued", 32'(alu_fun), 32'(ce_fun[n_rise]));
            n_rise++;
          end
          prev_valid = res_valid;
        end
      end
    join
    chk("class_result_count", 32'(n_rise), 32'd4);
    repeat (3) @(posedge clk);
    #1;

    // ---- reset mid-operation: 1 in WAIT, 2 queued ----
    res_ready = 1'b0;
    push_cmd(4'd0, 16'd1, 16'd2);
    push_cmd(4'd0, 16'd3, 16'd4);
    push_cmd(4'd0, 16'd5, 16'd6);
    chk("midrst_pre_A_issued", 32'(a), 32'd1);
    chk("midrst_pre_busy", 32'(busy), 32'd1);
    chk("midrst_pre_valid_low", 32'(res_valid), 32'd0);
    #1 rst = 1'b1;             // between edges
    #1;
    check_reset_values("midrst");
    #1 rst = 1'b0;
    res_ready   = 1'b1;
    n_bad_valid = 0;
    n_bad_busy  = 0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (res_valid) n_bad_valid++;
      if (busy) n_bad_busy++;
    end
    chk("midrst_no_result_after_release", 32'(n_bad_valid), 32'd0);
    chk("midrst_no_busy_after_release", 32'(n_bad_busy), 32'd0);
    chk("midrst_A_stays_reset", 32'(a), 32'd0);
    chk("midrst_cmd_ready", 32'(cmd_ready), 32'd1);

    // ---- push and pop on the same edge with 2 queued ----
    @(posedge clk);
    #1;
    res_ready = 1'b0;
    push_cmd(4'd0, 16'd100, 16'd1);     // 101
    push_cmd(4'd1, 16'd100, 16'd1);     // 99
    push_cmd(4'd4, 16'hFF00, 16'h0FF0); // 0x0F00
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge clk);
      seen = res_valid;
    end
    chk("pp_first_result_ready", 32'(seen), 32'd1);
    chk("pp_first_result_data", 32'(res_data), 32'd101);
    @(posedge clk);
    #1;
    res_ready = 1'b1;
    cmd_fun   = 4'd13;
    cmd_a     = 16'h4000;
    cmd_b     = 16'h0000;
    cmd_valid = 1'b1;
    @(negedge clk);
    chk("pp_count_before", 32'(dut.count_q), 32'd2);
    chk("pp_cmd_ready", 32'(cmd_ready), 32'd1);
    @(posedge clk);                     // handshake pop + push together
    #1;
    res_ready = 1'b0;
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pp_count_after", 32'(dut.count_q), 32'd2);
    chk("pp_valid_cleared", 32'(res_valid), 32'd0);
    @(posedge clk);
    #1 res_ready = 1'b1;
    n_got = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid && res_ready && n_got < 8) begin
        got[n_got] = res_data;
        n_got++;
      end
    end
    chk("pp_result_count", 32'(n_got), 32'd3);
    if (n_got > 0) chk("pp_result_0", 32'(got[0]), 32'd99);
    if (n_got > 1) chk("pp_result_1", 32'(got[1]), 32'h0F00);
    if (n_got > 2) chk("pp_result_2", 32'(got[2]), 32'h8000);

    // ---- final report ----
    chk("final_exp_q_empty", 32'(exp_q.size()), 32'd0);
    chk("final_accepts", 32'(accepts), 32'd17);
    chk("final_results", 32'(results_seen), 32'd14);
    chk("final_busy", 32'(busy), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
